// File: rtl/envelope_stream_reader_if.sv
// Word-level links of the envelope stream reader: the interval-result strobe from the
// min/max engine and the framed valid/ready word stream toward the host link.
interface envelope_stream_reader_if;
  logic               in_valid;
  logic signed [31:0] in_max;
  logic signed [31:0] in_min;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] out_data;
  logic               out_last;

  modport slave (
    input  in_valid, in_max, in_min, in_last, out_ready,
    output out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_max, in_min, in_last, out_ready,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/envelope_stream_reader.sv
// Captures per-interval (max, min) results into a FIFO and streams each one out as a
// three-word frame (header, max, min); results arriving with the FIFO full are dropped.
module envelope_stream_reader #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  envelope_stream_reader_if.slave link,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow,
  output logic [IDX_W-1:0]        intervals_sent
);
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [15:0] HDR_TAG  = 16'hE4E0;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, MAX, MIN} state_t;

  typedef struct packed {
    logic                     last;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] max;
    logic signed [DATA_W-1:0] min;
  } entry_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: 16] = HDR_TAG;
    w[IDX_W-1:0]      = idx;
    return w;
  endfunction

  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]       count;
  logic [IDX_W-1:0]  wr_idx, idx_base, next_idx;
  logic              overflow_q;
  logic [IDX_W-1:0]  sent_q;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  entry_t            head;
  logic              accept, pop, full, wr_en, drop, start_ok;

  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign next_idx   = mem[rd_ptr_nxt].idx;

  assign link.out_valid = (state_q != IDLE);
  assign link.out_data  = data_q;
  assign link.out_last  = last_q;
  assign done           = done_q;
  assign busy           = (count != '0) || (state_q != IDLE);
  assign overflow       = overflow_q;
  assign intervals_sent = sent_q;

  assign accept   = link.out_valid && link.out_ready;
  assign start_ok = start && !busy;
  assign full     = (count == CNT_FULL);
  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign wr_en    = link.in_valid && (!full || pop);
  assign drop     = link.in_valid && !wr_en;
  assign idx_base = start_ok ? '0 : wr_idx;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = HDR;
          data_d  = make_header(head.idx);
          last_d  = 1'b0;
        end
      end
      HDR: begin
        if (accept) begin
          state_d = MAX;
          data_d  = $unsigned(head.max);
        end
      end
      MAX: begin
        if (accept) begin
          state_d = MIN;
          data_d  = $unsigned(head.min);
          last_d  = head.last;
        end
      end
      MIN: begin
        if (accept) begin
          pop    = 1'b1;
          done_d = last_q;
          last_d = 1'b0;
          // Chain straight into the next header when another entry is already stored.
          if (count > CNT_ONE) begin
            state_d = HDR;
            data_d  = make_header(next_idx);
          end else begin
            state_d = IDLE;
            data_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_idx     <= '0;
      overflow_q <= 1'b0;
      sent_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_nxt;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Index advances on every strobe, so a dropped result leaves a gap in the headers.
      wr_idx <= idx_base + IDX_W'(link.in_valid);
      if (start_ok)  overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      if (start_ok) sent_q <= '0;
      else if (pop) sent_q <= sent_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{last: link.in_last, idx: idx_base, max: link.in_max, min: link.in_min};
    end
  end
endmodule

// File: doc/envelope_stream_reader.md
# envelope_stream_reader

Consumer side of the per-interval min/max envelope. The interval min/max engine emits one (max, min) result per interval. This block captures each result into a small FIFO. It then streams every interval out as a three-word frame (header, max, min) over a valid/ready word interface toward the host/display link. It absorbs bursts from the engine, which cannot be back-pressured, and flags any results it has to drop.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- IDX_W, 7, width of interval index and sent counter; ≤16

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a new capture (clears index, overflow, sent count); honoured only when busy=0
- in_valid  in  1  one-cycle strobe, one interval result present
- in_max  in  32  signed interval maximum
- in_min  in  32  signed interval minimum
- in_last  in  1  qualifies in_valid: final interval of the capture
- out_valid  out  1  out_data holds a word
- out_ready  in  1  downstream accepts word this cycle
- out_data  out  32  stream word
- out_last  out  1  high with the min word of the in_last interval
- done  out  1  one-cycle pulse after the last-flagged min word is accepted
- busy  out  1  FIFO non-empty or a frame is in flight
- overflow  out  1  sticky; a result was dropped since the last start or reset
- intervals_sent  out  IDX_W  frames fully accepted since the last start; wraps

## Operation
- **FIFO entry:** {last, index[IDX_W-1:0], max[31:0], min[31:0]}.
- **Write index:** wr_idx increments on every in_valid, whether the entry is stored or dropped. A drop therefore shows as a gap in the header indices.
- **Write acceptance:** a write is stored if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the entry is dropped and overflow is set.
- **Frame format:**
  - header = {16'hE4E0, zero-pad, index}
  - then max, bit-exact
  - then min, bit-exact
- **FSM states:** IDLE, HDR, MAX, MIN. The state names the word currently presented.
- **IDLE:** out_valid=0. When the FIFO is non-empty, load the header of the head entry and go to HDR.
- **HDR:** on accept, present max and go to MAX.
- **MAX:** on accept, present min, set out_last = entry.last, and go to MIN.
- **MIN:** on accept:
  - pop the head entry and increment intervals_sent
  - pulse done next cycle if last=1
  - if FIFO count > 1 before the pop, present the next header and go to HDR; else go to IDLE with out_valid=0.
- **Stall rule:** while out_valid=1 and out_ready=0, out_data, out_last and the state are held stable.
- **start while busy=1:** ignored, with no side effects.
- **start while busy=0:** clears wr_idx, overflow and intervals_sent. If in_valid coincides with start, the entry is written with index 0.
- **busy:** busy = (count != 0) || (state != IDLE).

## Timing
- Reset (asynchronous, reset_n=0): out_valid=0, out_data=0, out_last=0, done=0, busy=0, overflow=0, intervals_sent=0, wr_idx=0, FIFO empty, state IDLE. Normal operation resumes on the first clk edge after deassertion.
- Latency: in_valid sampled at edge E → header presented with out_valid=1 after edge E+1.
- Throughput, with out_ready held high:
  - 3 cycles per frame
  - no bubble between back-to-back frames when the FIFO already holds the next entry
  - a 1-cycle IDLE bubble when the next entry arrives in the same cycle as the MIN accept
- done rises in the cycle after the last-flagged min word is accepted and lasts exactly 1 cycle.
- overflow is set in the cycle after the dropped strobe.
- reset_n asserted mid-frame aborts immediately. The partial frame is not completed.

## Test plan
- **Single interval:**
  - stimulus: start; in_valid with max=0x00001234, min=0xFFFFF000 (-4096), last=1; out_ready=1
  - required: out_data 0xE4E00000, 0x00001234, 0xFFFFF000 on consecutive cycles; out_last only on the third word; done pulse; intervals_sent=1; busy=0 afterwards.
- **Backpressure:** 3 intervals, out_ready toggled 1,0,0,1,...
  - required: words unchanged while stalled; header indices 0,1,2; 9 words total; no overflow.
- **Overflow:**
  - stimulus: DEPTH=16, out_ready=0; 18 in_valid strobes; then out_ready=1
  - required: overflow=1; exactly 16 frames with indices 0–15; intervals_sent=16.
- **Full plus simultaneous pop:** FIFO full, with in_valid in the same cycle as a MIN accept.
  - required: entry stored; overflow stays 0.
- **start handling:**
  - start asserted while busy: no effect on indices.
  - start asserted after drain: next header index restarts at 0; overflow cleared.
- **Mid-frame reset:** reset_n pulsed low after the max word is accepted.
  - required: out_valid=0 immediately; all outputs at reset values; a fresh interval then produces index 0.
